uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the CPU external memory bus, directly downstream of `microprocessor_system`. It decodes CPU stores to the UART window at 0x10000000 and buffers the bytes in a FIFO. It serializes each byte as 8N1 (optionally 8E1) on `tx`. It stalls the CPU through `ext_mem_ready` only when the FIFO is full.

---
 rtl/uart_tx_mmio.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS window, byte FIFO, 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic        ext_mem_read,
    input  logic        ext_mem_write,
    input  logic        ext_mem_enable,
    output logic        ext_mem_ready,
    output logic [31:0] ext_rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] BaudMax = CntW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW:0]   wptr_q, rptr_q;
    logic [PtrW:0]   count;
    logic [31:0]     count_ext;
    logic [3:0]      count_disp;
    logic            full, empty;
    logic            push, pop;

    logic            sel, wr_data, rd_status;
    logic [31:0]     status;
    logic            unused_bits;

    // Bus decode
    assign sel       = ext_mem_enable && (ext_addr[31:3] == BASE_ADDR[31:3]);
    assign wr_data   = sel && ext_mem_write && !ext_addr[2];
    assign rd_status = sel && ext_mem_read && ext_addr[2];
    assign push      = wr_data && !full;
    assign unused_bits = ^{ext_addr[1:0], ext_wdata[31:8]};

    // FIFO status from registered pointers; the wrap bit separates full from empty
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign count      = wptr_q - rptr_q;
    assign count_ext  = 32'(count);
    assign count_disp = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    assign status = {20'b0, count_disp, 5'b0, (state_q != StIdle), empty, full};

    assign ext_mem_ready = !(wr_data && full);
    assign ext_rdata     = rd_status ? status : 32'b0;
    assign tx            = tx_q;
    assign tx_busy       = (state_q != StIdle) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[PtrW-1:0]] <= ext_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + (PtrW+1)'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + (PtrW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx is registered, so each branch sets the level for the upcoming bit
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q[PtrW-1:0]];
                    baud_d  = BaudMax;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_q == '0) begin
                    baud_d  = BaudMax;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q - CntW'(1);
                end
            end
            StData: begin
                if (baud_q == '0) begin
                    baud_d = BaudMax;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^shift_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q - CntW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_q == '0) begin
                    baud_d  = BaudMax;
                    tx_d    = 1'b1;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q - CntW'(1);
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (baud_q == '0) begin
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q - CntW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: expected bytes and STATUS values are queued at
// issue time and checked by independent serial-line and bus monitors.
module tb_uart_tx_mmio;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    logic        clk;
    logic        rst_n;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_mem_read;
    logic        ext_mem_write;
    logic        ext_mem_enable;
    logic        ext_mem_ready;
    logic [31:0] ext_rdata;
    logic        tx;
    logic        tx_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] rd_q[$];

    uart_tx_mmio #(
        .BASE_ADDR (32'h1000_0000),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ext_addr      (ext_addr),
        .ext_wdata     (ext_wdata),
        .ext_mem_read  (ext_mem_read),
        .ext_mem_write (ext_mem_write),
        .ext_mem_enable(ext_mem_enable),
        .ext_mem_ready (ext_mem_ready),
        .ext_rdata     (ext_rdata),
        .tx            (tx),
        .tx_busy       (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        ext_mem_enable = 1'b0;
        ext_mem_write  = 1'b0;
        ext_mem_read   = 1'b0;
        ext_addr       = '0;
        ext_wdata      = '0;
    endtask

    // Returns after the accepting edge; stalls counts cycles with ext_mem_ready low
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int stalls);
        @(negedge clk);
        ext_addr = a; ext_wdata = d;
        ext_mem_enable = 1'b1; ext_mem_write = 1'b1; ext_mem_read = 1'b0;
        stalls = 0;
        #1;
        while (!ext_mem_ready && stalls < 2000) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] expv);
        @(negedge clk);
        rd_q.push_back(expv);
        ext_addr = a;
        ext_mem_enable = 1'b1; ext_mem_read = 1'b1; ext_mem_write = 1'b0;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (tx_busy && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (tx_busy) chk(name, 32'(n), 32'(max + 1));
    endtask

    // Bus monitor: compare every enabled read against the queued expectation
    initial begin : bus_mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (ext_mem_enable && ext_mem_read) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_read", 32'd1, 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    chk("rdata", ext_rdata, e);
                    chk("rd_ready", 32'(ext_mem_ready), 32'd1);
                end
            end
        end
    end

    // Serial monitor: decode one frame per start edge, sampling mid-bit
    initial begin : ser_mon
        logic [10:0] bits;
        logic [7:0]  e;
        logic        aborted;
        forever begin
            @(negedge tx);
            aborted = !rst_n;
            bits = '0;
            for (int b = 0; b < NBITS && !aborted; b++) begin
                for (int k = 0; k < ((b == 0) ? CLK_DIV / 2 : CLK_DIV); k++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                end
                bits[b] = tx;
            end
            if (!aborted) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(bits), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("start_bit", 32'(bits[0]), 32'd0);
                    chk("data_byte", 32'(bits[8:1]), 32'(e));
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", 32'(bits[9]), 32'(^e));
`endif
                    chk("stop_bit", 32'(bits[NBITS-1]), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int st;
        int n;
        int sum;
        logic [7:0] fill [10];
        fill = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h7E, 8'h81};

        // Reset
        bus_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_ready", 32'(ext_mem_ready), 32'd1);
        chk("rst_rdata", ext_rdata, 32'd0);
        rst_n = 1'b1;
        bus_read(32'h1000_0004, 32'h0000_0002);

        // Single byte 0x55: count visible before pop, tx falls one edge later
        exp_q.push_back(8'h55);
        bus_write(32'h1000_0000, 32'h0000_0055, st);
        chk("single_stall", 32'(st), 32'd0);
        chk("tx_before_pop", 32'(tx), 32'd1);
        bus_read(32'h1000_0004, 32'h0000_0100);
        chk("tx_start_fall", 32'(tx), 32'd0);
        n = 0;
        while (tx_busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("frame_len_55", 32'(n), 32'(FRAME));
        repeat (4) @(posedge clk);

        // Decode: out-of-window and wrong-register cycles have no effect
        @(negedge clk);
        ext_addr = 32'h1000_0008; ext_wdata = 32'h0000_00AA;
        ext_mem_enable = 1'b1; ext_mem_write = 1'b1;
        #1;
        chk("dec_hi_ready", 32'(ext_mem_ready), 32'd1);
        chk("dec_hi_rdata", ext_rdata, 32'd0);
        @(posedge clk);
        #1;
        ext_addr = 32'h0FFF_FFFC;
        @(negedge clk);
        #1;
        chk("dec_lo_ready", 32'(ext_mem_ready), 32'd1);
        chk("dec_lo_rdata", ext_rdata, 32'd0);
        @(posedge clk);
        #1;
        bus_idle();
        bus_write(32'h1000_0004, 32'h0000_00BB, st);
        bus_read(32'h1000_0000, 32'h0000_0000);
        bus_read(32'h1000_000C, 32'h0000_0000);
        bus_read(32'h1000_0004, 32'h0000_0002);
        chk("dec_busy", 32'(tx_busy), 32'd0);

        // Fill and stall
        sum = 0;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(fill[i]);
            bus_write(32'h1000_0000, 32'(fill[i]), st);
            sum += st;
        end
        chk("fill_no_stall", 32'(sum), 32'd0);
        bus_read(32'h1000_0004, 32'h0000_0805);
        exp_q.push_back(fill[9]);
        bus_write(32'h1000_0000, 32'(fill[9]), st);
        chk("stall_cycles", 32'(st), 32'(FRAME - 7));
        wait_idle("fill_drain_timeout", 2000);
        repeat (4) @(posedge clk);

        // Reset during data bit 3 of 0xA3; no frame expected
        bus_write(32'h1000_0000, 32'h0000_00A3, st);
        @(posedge clk);
        #1;
        repeat (4 * CLK_DIV + CLK_DIV / 2) @(posedge clk);
        #1;
        chk("bit3_low", 32'(tx), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(tx_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_read(32'h1000_0004, 32'h0000_0002);
        repeat (FRAME) @(posedge clk);

        // Parity byte 0x07 (three ones)
        exp_q.push_back(8'h07);
        bus_write(32'h1000_0000, 32'h0000_0007, st);
        @(posedge clk);
        #1;
        chk("par_tx_fall", 32'(tx), 32'd0);
        n = 0;
        while (tx_busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("frame_len_07", 32'(n), 32'(FRAME));

        repeat (20) @(posedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
